dac_wave_seq: RTL and testbench

Waveform sequencer that sits directly upstream of the TLV5618 serial driver (`tlv5618`). It generates a 12-bit sample stream at a fixed update rate and packs each sample into a 16-bit TLV5618 control word (channel A latch write). It then issues one `Start` per sample and waits for the driver's `Set_Done` before issuing the next. It replaces the constant control word and key-driven start with a continuous, rate-controlled DAC update source.

---
 rtl/dac_pkg.sv | 36 +++
 rtl/dac_wave_gen.sv | 64 ++++++
 rtl/dac_wave_seq.sv | 160 ++++++++++++++++
 tb/tb_dac_wave_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC waveform sequencer: waveform modes,
// TLV5618 control bits, sequencer states and the control-word packer.
package dac_pkg;

  localparam int SAMPLE_W = 12;

  // Waveform selection
  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_SQR  = 2'd3;

  // TLV5618 register select, encoded as {R1, R0}
  localparam logic [1:0] CTL_WR_A = 2'b10;  // write channel A latch
  localparam logic [1:0] CTL_WR_B = 2'b00;  // write channel B latch and buffer
  localparam logic [1:0] CTL_BUF  = 2'b01;  // write double buffer only

  // Triangle direction
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_SEND,
    ST_WAIT_DONE
  } seq_state_t;

  // TLV5618 word layout: {R1, SPD, PWR, R0, D11..D0}; PWR kept at 0 (powered up)
  function automatic logic [15:0] pack_word(input logic [1:0]          ctl,
                                            input logic                spd,
                                            input logic [SAMPLE_W-1:0] sample);
    return {ctl[1], spd, 1'b0, ctl[0], sample};
  endfunction

endpackage

// File: rtl/dac_wave_gen.sv
// Combinational next-sample logic: given the current phase state and the
// waveform settings, produce the sample and the phase state after one tick.
module dac_wave_gen
  import dac_pkg::*;
(
  input  logic [1:0]          mode,
  input  logic [SAMPLE_W-1:0] acc,
  input  logic                dir,
  input  logic                sq,
  input  logic [SAMPLE_W-1:0] step,
  input  logic [SAMPLE_W-1:0] level,
  output logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] acc_next,
  output logic                dir_next,
  output logic                sq_next
);

  // One extra bit so the triangle can detect passing full scale
  logic [SAMPLE_W:0] sum;

  // Per-mode phase update; anything a mode does not touch holds its value
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, step};
    acc_next = acc;
    dir_next = dir;
    sq_next  = sq;
    sample   = level;
    case (mode)
      MODE_HOLD: begin
        sample = level;
      end
      MODE_SAW: begin
        acc_next = sum[SAMPLE_W-1:0];
        sample   = sum[SAMPLE_W-1:0];
      end
      MODE_TRI: begin
        if (dir == DIR_UP) begin
          if (sum[SAMPLE_W]) begin
            acc_next = '1;
            dir_next = DIR_DOWN;
          end else begin
            acc_next = sum[SAMPLE_W-1:0];
          end
        end else begin
          if (acc < step) begin
            acc_next = '0;
            dir_next = DIR_UP;
          end else begin
            acc_next = acc - step;
          end
        end
        sample = acc_next;
      end
      MODE_SQR: begin
        sq_next = ~sq;
        sample  = sq_next ? level : '0;
      end
      default: begin
        sample = level;
      end
    endcase
  end

endmodule

// File: rtl/dac_wave_seq.sv
// Rate-controlled waveform source for the TLV5618 serial driver. Each sample
// tick produces one channel-A control word, fires one start pulse and waits
// for the driver's done before another tick can be accepted.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | disabled, no transaction outstanding
//   ST_WAIT_TICK | enabled, waiting for the next sample tick
//   ST_SEND      | word registered, start pulse driven this cycle
//   ST_WAIT_DONE | driver shifting the word out, waiting for done
module dac_wave_seq
  import dac_pkg::*;
#(
  parameter int UPDATE_DIV = 5000,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] step,
  input  logic              fast,
  output logic [15:0]       dac_data,
  output logic              dac_start,
  input  logic              dac_done,
  output logic              busy,
  output logic              overrun
);

  localparam int              CNT_W    = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_DIV - 1);

  seq_state_t state, state_next;

  logic [CNT_W-1:0]    cnt;
  logic                en_q;
  logic                en_rise;
  logic                tick;
  logic                accept;
  logic                drop;

  logic [SAMPLE_W-1:0] acc;
  logic                dir;
  logic                sq;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] acc_next;
  logic                dir_next;
  logic                sq_next;

  assign en_rise = en & ~en_q;
  assign tick    = en && (cnt == CNT_LAST);
  assign accept  = tick && (state == ST_WAIT_TICK);
  // A tick during an outstanding transaction is discarded, never queued
  assign drop    = tick && ((state == ST_SEND) || (state == ST_WAIT_DONE));

  assign dac_start = (state == ST_SEND);
  assign busy      = (state == ST_SEND) || (state == ST_WAIT_DONE);

  // Sample-rate counter, parked at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Enable history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state; disabling only takes effect between transactions
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (en) state_next = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!en)       state_next = ST_IDLE;
        else if (tick) state_next = ST_SEND;
      end
      ST_SEND: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (dac_done) state_next = en ? ST_WAIT_TICK : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  dac_wave_gen u_gen (
    .mode     (mode),
    .acc      (acc),
    .dir      (dir),
    .sq       (sq),
    .step     (step),
    .level    (level),
    .sample   (sample),
    .acc_next (acc_next),
    .dir_next (dir_next),
    .sq_next  (sq_next)
  );

  // Phase state: restarts on enable, advances only on accepted ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      dir <= DIR_UP;
      sq  <= 1'b0;
    end else if (en_rise) begin
      acc <= '0;
      dir <= DIR_UP;
      sq  <= 1'b0;
    end else if (accept) begin
      acc <= acc_next;
      dir <= dir_next;
      sq  <= sq_next;
    end
  end

  // Control word is captured at the accepted tick and held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data <= '0;
    end else if (accept) begin
      dac_data <= pack_word(CTL_WR_A, fast, sample);
    end
  end

  // Single-cycle pulse for each dropped tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
    end
  end

endmodule

// File: tb/tb_dac_wave_seq.sv
// Bench for dac_wave_seq: directed waveform scenarios plus randomized
// segments, checked against an arithmetic waveform model and a timing model
// for tick acceptance derived from the driver latency.
module tb_dac_wave_seq;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] level;
  logic [11:0] step;
  logic        fast;
  logic [15:0] dac_data;
  logic        dac_start;
  logic        dac_done;
  logic        busy;
  logic        overrun;

  dac_wave_seq #(.UPDATE_DIV(DIV), .DATA_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .level     (level),
    .step      (step),
    .fast      (fast),
    .dac_data  (dac_data),
    .dac_start (dac_start),
    .dac_done  (dac_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Waveform model state
  int acc_m, dir_m, sq_m;

  function automatic void model_reset();
    acc_m = 0;
    dir_m = 1;
    sq_m  = 0;
  endfunction

  function automatic int model_next(input int md, input int lv, input int st, input int fs);
    int s, n;
    case (md)
      0: s = lv;
      1: begin
        acc_m = (acc_m + st) % 4096;
        s = acc_m;
      end
      2: begin
        n = acc_m + dir_m * st;
        if (n > 4095) begin
          acc_m = 4095;
          dir_m = -1;
        end else if (n < 0) begin
          acc_m = 0;
          dir_m = 1;
        end else begin
          acc_m = n;
        end
        s = acc_m;
      end
      default: begin
        sq_m = 1 - sq_m;
        s = (sq_m != 0) ? lv : 0;
      end
    endcase
    return 32768 + fs * 16384 + s;
  endfunction

  // Ticks needed per transaction: next tick accepted only once done has cleared
  int lat;
  function automatic int ticks_per_txn();
    return (lat + 2 + DIV - 1) / DIV;
  endfunction

  // Monitor / driver shared state
  int cyc = 0;
  int cd = 0;
  int start_cnt = 0;
  int ov_cnt = 0;
  int prev_cyc = 0;
  int rise_cyc = 0;
  int have_prev = 0;
  int busy_run = 0;
  int busy_prev = 0;
  int word_valid = 0;
  int last_word = 0;
  int seen_q[$];
  logic [1:0]  cap_mode;
  logic [11:0] cap_level, cap_step;
  logic        cap_fast;

  // Inputs as the DUT sees them at each active edge
  always @(posedge clk) begin
    cyc++;
    cap_mode  = mode;
    cap_level = level;
    cap_step  = step;
    cap_fast  = fast;
  end

  // Driver model: done pulse lat cycles after each start
  always @(posedge clk) begin
    #1;
    dac_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) dac_done = 1'b1;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ov_cnt++;
      if (dac_start) begin
        check_val("word", int'(dac_data),
                  model_next(int'(cap_mode), int'(cap_level), int'(cap_step), int'(cap_fast)));
        seen_q.push_back(int'(dac_data));
        start_cnt++;
        if (have_prev != 0) begin
          check_val("start_gap", cyc - prev_cyc, ticks_per_txn() * DIV);
          check_val("overrun_cnt", ov_cnt, ticks_per_txn() - 1);
        end else begin
          check_val("first_start", cyc - rise_cyc, DIV);
        end
        have_prev  = 1;
        prev_cyc   = cyc;
        ov_cnt     = 0;
        last_word  = int'(dac_data);
        word_valid = 1;
        cd         = lat;
      end else if (word_valid != 0) begin
        check_val("data_stable", int'(dac_data), last_word);
      end
      if (busy) begin
        busy_run++;
      end else if (busy_prev != 0) begin
        check_val("busy_len", busy_run, lat + 1);
        busy_run = 0;
      end
      busy_prev = int'(busy);
    end
  end

  task automatic wait_starts(input int n, input int budget);
    int tgt, i;
    tgt = start_cnt + n;
    i = 0;
    while (start_cnt < tgt && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check_val("start_timeout", int'(start_cnt >= tgt), 1);
  endtask

  task automatic start_seg();
    @(posedge clk);
    #2;
    model_reset();
    have_prev = 0;
    ov_cnt    = 0;
    rise_cyc  = cyc;
    en        = 1'b1;
  endtask

  task automatic stop_seg();
    int n, sc;
    @(posedge clk);
    #2;
    en = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_val("drain_busy", int'(busy), 0);
    sc = start_cnt;
    repeat (3 * DIV) @(posedge clk);
    #2;
    check_val("idle_no_start", start_cnt, sc);
  endtask

  task automatic check_table(input string tag, input int base, input int exp[]);
    foreach (exp[i]) check_val(tag, seen_q[base + i], exp[i]);
  endtask

  int exp_saw[]  = '{32'hC400, 32'hC800, 32'hCC00, 32'hC000, 32'hC400};
  int exp_tri[]  = '{32'h8600, 32'h8C00, 32'h8FFF, 32'h89FF, 32'h83FF, 32'h8000, 32'h8600};
  int exp_hsq[]  = '{32'h87FF, 32'h87FF, 32'h87FF, 32'h8000, 32'h87FF, 32'h8000};
  int exp_ovr[]  = '{32'hC100, 32'hC200, 32'hC300, 32'hC400};
  int ovr_lat[]  = '{12, 7, 6};

  initial begin
    int base, n, tgt;
    rst = 1'b1; en = 1'b0; mode = 2'd0; level = 12'd0; step = 12'd0;
    fast = 1'b0; dac_done = 1'b0; lat = 5;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_data", int'(dac_data), 0);
    check_val("rst_start", int'(dac_start), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Sawtooth with wrap, plus a stray done while waiting for a tick
    mode = 2'd1; step = 12'h400; fast = 1'b1; lat = 5;
    base = seen_q.size();
    start_seg();
    wait_starts(5, 200);
    check_table("saw", base, exp_saw);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    dac_done = 1'b1;
    wait_starts(2, 100);
    stop_seg();

    // Triangle with saturation at both ends
    mode = 2'd2; step = 12'h600; fast = 1'b0; lat = 5;
    base = seen_q.size();
    start_seg();
    wait_starts(7, 200);
    check_table("tri", base, exp_tri);
    stop_seg();

    // Hold, then switch to square while a word is in flight
    mode = 2'd0; level = 12'h7FF; fast = 1'b0; lat = 5;
    base = seen_q.size();
    start_seg();
    wait_starts(2, 100);
    @(posedge clk);
    #2;
    mode = 2'd3;
    wait_starts(4, 100);
    check_table("hold_sqr", base, exp_hsq);
    stop_seg();

    // Slow driver: dropped ticks, including tick coinciding with done
    foreach (ovr_lat[i]) begin
      mode = 2'd1; step = 12'h100; fast = 1'b1; lat = ovr_lat[i];
      base = seen_q.size();
      start_seg();
      wait_starts(4, 300);
      check_table("ovr_words", base, exp_ovr);
      stop_seg();
    end

    // Disable mid-transaction, re-enable restarts phase
    mode = 2'd1; step = 12'h400; fast = 1'b1; lat = 5;
    start_seg();
    wait_starts(3, 100);
    stop_seg();
    start_seg();
    wait_starts(1, 100);
    check_val("reenable_word", seen_q[seen_q.size() - 1], 32'hC400);

    // Reset asserted while start is high
    wait_starts(1, 100);
    rst = 1'b1;
    en  = 1'b0;
    cd  = 0;
    busy_prev = 0; busy_run = 0; have_prev = 0; word_valid = 0;
    #1;
    check_val("midrst_start", int'(dac_start), 0);
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_data", int'(dac_data), 0);
    check_val("midrst_overrun", int'(overrun), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    start_seg();
    wait_starts(1, 100);
    check_val("post_rst_word", seen_q[seen_q.size() - 1], 32'hC400);
    stop_seg();

    // Randomized segments with occasional setting changes between ticks
    for (int s = 0; s < 6; s++) begin
      mode  = 2'($urandom_range(0, 3));
      level = 12'($urandom_range(0, 4095));
      step  = 12'($urandom_range(0, 4095));
      fast  = 1'($urandom_range(0, 1));
      lat   = $urandom_range(1, 14);
      start_seg();
      tgt = start_cnt + 5;
      n = 0;
      while (start_cnt < tgt && n < 400) begin
        @(posedge clk);
        #2;
        n++;
        if ($urandom_range(0, 15) == 0) begin
          mode  = 2'($urandom_range(0, 3));
          level = 12'($urandom_range(0, 4095));
          step  = 12'($urandom_range(0, 4095));
          fast  = 1'($urandom_range(0, 1));
        end
      end
      check_val("rand_timeout", int'(start_cnt >= tgt), 1);
      stop_seg();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
